// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU arithmetic unit (multiplier, divider).
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ADD,
    DONE
  } mac_state_t;

endpackage

// File: rtl/mac_multiplier_if.sv
// Start/done handshake and operand/result bus of the multiply-accumulate unit.
interface mac_multiplier_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       c;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       result;
  logic                   ovf;

  modport master (
    output start, a, b, c,
    input  busy, done, product, result, ovf
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, product, result, ovf
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {A[WIDTH:0], Q[WIDTH-1:0], q_1} register.
module booth_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH+1:0] acc_next
);

  logic [WIDTH:0] a_hi;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] a_new;

  always_comb begin
    a_hi  = acc[2*WIDTH+1:WIDTH+1];
    a_ext = {mcand[WIDTH-1], mcand};
    a_new = a_hi;
    case (acc[1:0])
      2'b01:   a_new = a_hi + a_ext;
      2'b10:   a_new = a_hi - a_ext;
      default: a_new = a_hi;
    endcase
    // Arithmetic shift right: A's sign bit is replicated, Q[0] becomes the new q_1.
    acc_next = {a_new[WIDTH], a_new, acc[WIDTH:1]};
  end

endmodule

// File: rtl/mac_multiplier.sv
// Sequential signed a*b + c using radix-2 Booth, one multiplier bit per cycle.
module mac_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_multiplier_if.slave  bus
);

  localparam int REG_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  mac_state_t           state;
  mac_state_t           state_nxt;
  logic [REG_W-1:0]     booth_q;
  logic [REG_W-1:0]     booth_d;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     addend_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ovf_q;
  logic [2*WIDTH-1:0]   sum;
  logic [WIDTH:0]       sum_top;
  logic                 sum_ovf;
  logic                 last_step;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc      (booth_q),
    .mcand    (mcand_q),
    .acc_next (booth_d)
  );

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Raw product {A[WIDTH-1:0], Q} is exact, so the sign-extended add cannot wrap.
  assign sum     = booth_q[2*WIDTH:1] + {{WIDTH{addend_q[WIDTH-1]}}, addend_q};
  assign sum_top = sum[2*WIDTH-1:WIDTH-1];
  assign sum_ovf = !((&sum_top) || (~|sum_top));

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) cnt_q <= '0;
        CALC: cnt_q <= cnt_q + CNT_W'(1);
        ADD: begin
          product_q <= sum;
          ovf_q     <= sum_ovf;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand and Booth registers are left unreset; they are always loaded at start before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mcand_q  <= bus.a;
      addend_q <= bus.c;
      booth_q  <= {{(WIDTH + 1){1'b0}}, bus.b, 1'b0};
    end else if (state == CALC) begin
      booth_q  <= booth_d;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;
  assign bus.result  = product_q[WIDTH-1:0];
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mac_multiplier.sv
// Self-checking bench for mac_multiplier: directed vectors, handshake corners, random ops.
module tb_mac_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_multiplier_if #(.WIDTH(8)) bus ();

  mac_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string             name;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [7:0] c;
    logic [15:0]       product;
    logic [7:0]        result;
    logic              ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int mac_model(input logic signed [7:0] x, input logic signed [7:0] y,
                                   input logic signed [7:0] z);
    return int'(x) * int'(y) + int'(z);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [7:0] tc, input logic [15:0] ep, input logic [7:0] er,
                        input logic eo);
    int lat = 0;
    bus.a = ta; bus.b = tb_; bus.c = tc; bus.start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c = 8'($urandom);
        check({nm, " busy_after_start"}, 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check({nm, " done_latency"}, lat, 10);
    check({nm, " product"}, 32'(bus.product), 32'(ep));
    check({nm, " result"}, 32'(bus.result), 32'(er));
    check({nm, " ovf"}, 32'(bus.ovf), 32'(eo));
    @(negedge clk);
    check({nm, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int done_cnt;
    int first_done;
    int p;
    logic signed [7:0] ra, rb, rc;

    vecs[0] = '{"mul_7x3",       8'sd7,    8'sd3,   8'sd0,    16'h0015, 8'h15, 1'b0};
    vecs[1] = '{"max_pos",       -8'sd128, -8'sd128, 8'sd127, 16'h407F, 8'h7F, 1'b1};
    vecs[2] = '{"max_neg",       -8'sd128, 8'sd127, -8'sd128, 16'hC000, 8'h00, 1'b1};
    vecs[3] = '{"div_inverse",   -8'sd14,  8'sd7,   -8'sd2,   16'hFF9C, 8'h9C, 1'b0};

    // Reset held with start asserted: reset must win.
    rst_n = 1'b0; bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; bus.c = 8'd1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.product), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset ovf", 32'(bus.ovf), 32'd0);

    // The first edge with rst_n=1 accepts the start driven alongside it.
    rst_n = 1'b1;
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].product, vecs[i].result, vecs[i].ovf);

    // start during CALC (cycle 3) and during DONE (cycle 10) must be ignored.
    bus.a = 8'd5; bus.b = 8'd5; bus.c = 8'd0; bus.start = 1'b1;
    done_cnt = 0; first_done = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      bus.start = (n == 3 || n == 10);
      if (n == 3) begin bus.a = 8'd9; bus.b = 8'd9; bus.c = 8'd9; end
    end
    @(negedge clk);
    check("ignore done_count", done_cnt, 1);
    check("ignore done_cycle", first_done, 10);
    check("ignore product", 32'(bus.product), 32'd25);
    check("ignore idle_after_done", 32'(bus.busy), 32'd0);
    run_op("back_to_back", 8'hFF, 8'hFF, 8'h00, 16'h0001, 8'h01, 1'b0);

    // Reset pulse in cycle 4 discards the in-flight operation.
    bus.a = 8'd100; bus.b = 8'd100; bus.c = 8'd0; bus.start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset product", 32'(bus.product), 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    check("midreset no_done", done_cnt, 0);
    run_op("after_reset", 8'd100, 8'd100, 8'd0, 16'h2710, 8'h10, 1'b1);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      if (i == 0) begin ra = -8'sd1; rb = 8'sd127; rc = -8'sd128; end
      p = mac_model(ra, rb, rc);
      run_op($sformatf("rand%0d", i), ra, rb, rc, p[15:0], p[7:0], (p < -128) || (p > 127));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_multiplier.md
# mac_multiplier

Sequential signed multiply-accumulate unit for the 8-bit ALU arithmetic unit: computes `a*b + c` over operands held at `start` using radix-2 Booth recoding, one multiplier bit per cycle. It performs the inverse of the divide path: feeding it `(quotient, divisor, remainder)` reconstructs the dividend. It sits beside the divider in the arithmetic unit and gives the ALU its MUL/MAC results through a start/done handshake.

## Interface
- `WIDTH`, 8, operand width in bits. Product width is 2*WIDTH. Iteration count is WIDTH.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset: synchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  signed multiplicand; latched when start is accepted.
- `b`  in  WIDTH  signed multiplier; latched when start is accepted.
- `c`  in  WIDTH  signed addend; latched when start is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `product`  out  2*WIDTH  signed `a*b + c`, full precision.
- `result`  out  WIDTH  low WIDTH bits of `product`.
- `ovf`  out  1  `product` cannot be represented in WIDTH signed bits.

## Operation
- FSM states:
  - IDLE: start=1 latches a/b/c, clears the accumulator and the counter, then goes to CALC.
  - CALC: runs WIDTH Booth steps, then goes to ADD.
  - ADD: adds sign-extended c to the product, then goes to DONE.
  - DONE: done=1 for one cycle, then back to IDLE.
- Booth register layout: {A[WIDTH:0], Q[WIDTH-1:0], q_1}.
  - A is WIDTH+1 bits so that negating -2^(WIDTH-1) does not overflow.
  - Init: A=0, Q=b, q_1=0.
- Each CALC cycle:
  - Pair {Q[0],q_1}: 01 means A += sext(a); 10 means A -= sext(a); 00 and 11 mean no change.
  - Then arithmetic-shift the whole register right by 1.
- After WIDTH steps the raw product is {A[WIDTH-1:0], Q}. This value is exact: |a*b| ≤ 2^(2*WIDTH-2).
- ADD: product = raw + sext(c, 2*WIDTH). The sum cannot wrap; for WIDTH=8 its range is [-16384, 16511].
- ovf = 1 when product[2*WIDTH-1:WIDTH-1] is not all-zeros and not all-ones.
- product, result and ovf update only at the ADD→DONE edge. They hold until the next accepted start reaches DONE.
- start while busy=1 is ignored, including the DONE cycle. No queueing.
- Operands changing after acceptance have no effect.

## Timing
- Start accepted at edge k:
  - busy=1 from edge k.
  - CALC runs on edges k+1..k+WIDTH.
  - ADD on edge k+WIDTH+1.
  - done=1 in the cycle after edge k+WIDTH+1.
  - IDLE again after edge k+WIDTH+2.
- For WIDTH=8: done is high in cycle 10 after the start cycle. Earliest back-to-back start is 11 cycles apart.
- Reset values: state=IDLE, busy=0, done=0, product=0, result=0, ovf=0, counter=0.
- rst_n=0 at any edge, including mid-CALC or during DONE: the next cycle has reset values and the in-flight operation is discarded.
- rst_n=0 together with start=1: reset wins and start is not accepted.
- The first start is accepted on the first edge where rst_n=1.

## Structure
- Shared package `alu_pkg`:
  - `mac_state_t` enum {IDLE, CALC, ADD, DONE}.
  - `DATA_W = 8`.
  - Shared with the other arithmetic-unit blocks.
- One sub-module: `booth_step`.
  - Combinational, parameterized by WIDTH.
  - Inputs: {A, Q, q_1} and the multiplicand.
  - Output: the next register value.
  - Instantiated once in `mac_multiplier`; unit-testable on its own.
- The counter is $clog2(WIDTH+1) bits.

## Test plan
- 7, 3, 0 -> product=21, result=0x15, ovf=0; done exactly 10 cycles after the start cycle and high for exactly one cycle.
- -128, -128, 127 -> product=16511 (0x407F), result=0x7F, ovf=1.
- -128, 127, -128 -> product=-16384 (0xC000), result=0x00, ovf=1.
- Inverse of division (dividend -100 by divisor 7 gives quotient -14, remainder -2): -14, 7, -2 -> product=-100 (0xFF9C), result=0x9C, ovf=0.
- start pulsed at cycles 3 and 10 (the DONE cycle) after a 5×5+0 start → both ignored. One done only, product=25. A new start at cycle 11 with -1, -1, 0 → product=1.
- rst_n low for one cycle at cycle 4 of a 100×100+0 operation:
  - Next cycle: busy=0, done=0, product=0; no done pulse ever appears for that operation.
  - A subsequent start with 100, 100, 0 → product=10000, ovf=1.
